// File: rtl/time_bus_ctrl_if.sv
// Shared counter read bus, one-hot enable/load strobes, set-time handshake and
// coherent H:M:S snapshot outputs between time_bus_ctrl and its neighbours.
interface time_bus_ctrl_if #(
    parameter int unsigned W = 6
);
    logic [W-1:0] databus;
    logic         tick;
    logic [2:0]   en_sel;
    logic [2:0]   ld_sel;
    logic [W-1:0] ld_data;
    logic         wr_req;
    logic [1:0]   wr_sel;
    logic [W-1:0] wr_data;
    logic         wr_ack;
    logic         wr_err;
    logic [W-1:0] snap_sec;
    logic [W-1:0] snap_min;
    logic [W-1:0] snap_hour;
    logic         snap_vld;

    modport master (
        input  databus, tick, wr_req, wr_sel, wr_data,
        output en_sel, ld_sel, ld_data, wr_ack, wr_err,
               snap_sec, snap_min, snap_hour, snap_vld
    );

    modport slave (
        output databus, tick, wr_req, wr_sel, wr_data,
        input  en_sel, ld_sel, ld_data, wr_ack, wr_err,
               snap_sec, snap_min, snap_hour, snap_vld
    );
endinterface

// File: rtl/time_bus_ctrl.sv
// Bus master for the sec/min/hour counters: periodic coherent scans into a
// snapshot, and arbitration of set-time writes into one-cycle load strobes.
module time_bus_ctrl #(
    parameter int unsigned W        = 6,
    parameter int unsigned SEC_MAX  = 59,
    parameter int unsigned MIN_MAX  = 59,
    parameter int unsigned HOUR_MAX = 23,
    parameter int unsigned SCAN_GAP = 4
) (
    input  logic            clk,
    input  logic            clear_n,
    time_bus_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, RD_S, RD_M, RD_H, WRITE} state_e;

    localparam int unsigned   GW       = (SCAN_GAP > 2) ? $clog2(SCAN_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((SCAN_GAP > 0) ? SCAN_GAP - 1 : 0);
    localparam logic [W-1:0]  SEC_LIM  = W'(SEC_MAX);
    localparam logic [W-1:0]  MIN_LIM  = W'(MIN_MAX);
    localparam logic [W-1:0]  HOUR_LIM = W'(HOUR_MAX);

    state_e        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          wr_blk_q, wr_blk_d;
    logic [W-1:0]  sh_sec_q, sh_sec_d;
    logic [W-1:0]  sh_min_q, sh_min_d;
    logic [2:0]    en_sel_q, en_sel_d;
    logic [2:0]    ld_sel_q, ld_sel_d;
    logic [W-1:0]  ld_data_q, ld_data_d;
    logic          wr_ack_q, wr_ack_d;
    logic          wr_err_q, wr_err_d;
    logic [W-1:0]  snap_sec_q, snap_sec_d;
    logic [W-1:0]  snap_min_q, snap_min_d;
    logic [W-1:0]  snap_hour_q, snap_hour_d;
    logic          snap_vld_q, snap_vld_d;

    logic wr_go;
    logic wr_legal;
    logic gap_done;

    // A request that was just served stays blocked until wr_req is seen low.
    always_comb begin
        wr_go    = bus.wr_req && !wr_blk_q;
        gap_done = (SCAN_GAP == 0) || (gap_q == GAP_LAST);
        unique case (bus.wr_sel)
            2'd0:    wr_legal = (bus.wr_data <= SEC_LIM);
            2'd1:    wr_legal = (bus.wr_data <= MIN_LIM);
            2'd2:    wr_legal = (bus.wr_data <= HOUR_LIM);
            default: wr_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        gap_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (wr_go) begin
                    state_d = WRITE;
                end else if (gap_done) begin
                    state_d = RD_S;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            // A tick before the hour read would tear the snapshot: rescan.
            RD_S:    state_d = bus.tick ? RD_S : RD_M;
            RD_M:    state_d = bus.tick ? RD_S : RD_H;
            RD_H:    state_d = (SCAN_GAP == 0 && !wr_go) ? RD_S : IDLE;
            WRITE:   state_d = RD_S;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they appear registered in it.
    always_comb begin
        en_sel_d    = '0;
        ld_sel_d    = '0;
        ld_data_d   = '0;
        wr_ack_d    = 1'b0;
        wr_err_d    = 1'b0;
        sh_sec_d    = sh_sec_q;
        sh_min_d    = sh_min_q;
        snap_sec_d  = snap_sec_q;
        snap_min_d  = snap_min_q;
        snap_hour_d = snap_hour_q;
        snap_vld_d  = 1'b0;
        wr_blk_d    = (state_d == WRITE) || (wr_blk_q && bus.wr_req);

        unique case (state_d)
            RD_S: en_sel_d = 3'b001;
            RD_M: en_sel_d = 3'b010;
            RD_H: en_sel_d = 3'b100;
            WRITE: begin
                if (wr_legal) begin
                    ld_sel_d  = 3'b001 << bus.wr_sel;
                    ld_data_d = bus.wr_data;
                    wr_ack_d  = 1'b1;
                end else begin
                    wr_err_d  = 1'b1;
                end
            end
            default: ;
        endcase

        if (state_q == RD_S) sh_sec_d = bus.databus;
        if (state_q == RD_M) sh_min_d = bus.databus;
        if (state_q == RD_H) begin
            snap_sec_d  = sh_sec_q;
            snap_min_d  = sh_min_q;
            snap_hour_d = bus.databus;
            snap_vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= IDLE;
            gap_q       <= '0;
            wr_blk_q    <= 1'b0;
            sh_sec_q    <= '0;
            sh_min_q    <= '0;
            en_sel_q    <= '0;
            ld_sel_q    <= '0;
            ld_data_q   <= '0;
            wr_ack_q    <= 1'b0;
            wr_err_q    <= 1'b0;
            snap_sec_q  <= '0;
            snap_min_q  <= '0;
            snap_hour_q <= '0;
            snap_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            wr_blk_q    <= wr_blk_d;
            sh_sec_q    <= sh_sec_d;
            sh_min_q    <= sh_min_d;
            en_sel_q    <= en_sel_d;
            ld_sel_q    <= ld_sel_d;
            ld_data_q   <= ld_data_d;
            wr_ack_q    <= wr_ack_d;
            wr_err_q    <= wr_err_d;
            snap_sec_q  <= snap_sec_d;
            snap_min_q  <= snap_min_d;
            snap_hour_q <= snap_hour_d;
            snap_vld_q  <= snap_vld_d;
        end
    end

    assign bus.en_sel    = en_sel_q;
    assign bus.ld_sel    = ld_sel_q;
    assign bus.ld_data   = ld_data_q;
    assign bus.wr_ack    = wr_ack_q;
    assign bus.wr_err    = wr_err_q;
    assign bus.snap_sec  = snap_sec_q;
    assign bus.snap_min  = snap_min_q;
    assign bus.snap_hour = snap_hour_q;
    assign bus.snap_vld  = snap_vld_q;
endmodule
